// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns indexed by hex value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with blanking gaps and frame-aligned updates.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             din_ready_q, din_ready_d;
  logic             frame_start_q, frame_start_d;
  logic [3:0]       digit;
  logic [6:0]       seg_dec;

  // Next-state: scan timing, pending register and frame-boundary swap
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q + CNT_W'(1);
    active_d      = active_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            frame_start_d = 1'b1;
            if (pend_full_q) begin
              active_d    = pend_q;
              pend_full_d = 1'b0;
            end
          end
        end
      end
    endcase
    // Accept only into an empty pending slot; a boundary swap needs it full, so the two never collide
    if (din_valid && din_ready_q) begin
      pend_d      = din;
      pend_full_d = 1'b1;
    end
    din_ready_d = ~pend_full_d;
  end

  assign digit = active_d[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex_i (digit),
    .seg_o (seg_dec)
  );

  // Outputs derived from next state so registered pins line up with the FSM state
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_d == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_dec;
`ifdef SEG_SCAN_LZB_EN
      if ((idx_d != 2'd0) && ((active_d >> {idx_d, 2'b00}) == 16'h0000)) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      din_ready_q   <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      din_ready_q   <= din_ready_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign din_ready   = din_ready_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: frame-position reference model plus directed literal checks.
module tb_seg_scan_driver;

  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: cycles since reset, displayed value, pending slot
  int          m_k = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  logic        m_full = 1'b0;

  seg_scan_driver #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, m_k, got, exp);
    end
  endtask

  // Expected {an, seg} from the frame position and the displayed value
  function automatic logic [10:0] expect_disp(input int k, input logic [15:0] act);
    int          pos;
    int          dig;
    logic [15:0] up;
    logic [3:0]  nib;
    logic [3:0]  one;
    pos = k % FRAME;
    dig = pos / SLOT;
    if ((pos % SLOT) < BC) return {4'b1111, 7'b1111111};
    up  = act >> (4 * dig);
    nib = up[3:0];
`ifdef SEG_SCAN_LZB_EN
    if (dig > 0 && up == 16'h0000) return {4'b1111, 7'b1111111};
`endif
    one = 4'b0001;
    return {~(one << dig), DEC[nib]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k      <= 0;
      m_active <= '0;
      m_full   <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (((m_k + 1) % FRAME == 0) && m_full) m_active <= m_pend;
      if (din_valid && !m_full) m_pend <= din;
      m_full <= (m_full && ((m_k + 1) % FRAME != 0)) || (din_valid && !m_full);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [10:0] e;
    if (chk_en) begin
      e = expect_disp(m_k, m_active);
      check("an", 16'(an), 16'(e[10:7]));
      check("seg", 16'(seg), 16'(e[6:0]));
      check("din_ready", 16'(din_ready), 16'(!m_full));
      check("frame_start", 16'(frame_start), 16'((m_k != 0) && (m_k % FRAME == 0)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v);
    din       = v;
    din_valid = 1'b1;
    cyc(1);
    din_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 3 * FRAME) begin
      cyc(1);
      n++;
    end
    if (frame_start !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_fs: frame_start=%b after %0d cycles, required 1", frame_start, n);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es);
    check({name, "_an"}, 16'(an), 16'(ea));
    check({name, "_seg"}, 16'(seg), 16'(es));
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    lit("reset", 4'b1111, 7'b1111111);
    check("reset_ready", 16'(din_ready), 16'd1);
    check("reset_fs", 16'(frame_start), 16'd0);
    rst = 1'b0;
    cyc(1);
    lit("post_reset", 4'b1111, 7'b1111111);
    cyc(1);
    lit("first_show", 4'b1110, 7'b1000000);

    // 0x1234 appears from the next frame
    send(16'h1234);
    wait_fs();
    cyc(2);
    lit("d0_4", 4'b1110, 7'b0011001);
    cyc(3);
    lit("d0_4_end", 4'b1110, 7'b0011001);
    cyc(1);
    lit("gap", 4'b1111, 7'b1111111);
    cyc(2);
    lit("d1_3", 4'b1101, 7'b0110000);
    cyc(6);
    lit("d2_2", 4'b1011, 7'b0100100);
    cyc(6);
    lit("d3_1", 4'b0111, 7'b1111001);

    // AAAA pending while 5555 is held valid
    din = 16'hAAAA;
    din_valid = 1'b1;
    cyc(1);
    din = 16'h5555;
    check("busy_ready", 16'(din_ready), 16'd0);
    wait_fs();
    check("swap_ready", 16'(din_ready), 16'd1);
    cyc(1);
    check("accept5555_ready", 16'(din_ready), 16'd0);
    din_valid = 1'b0;
    cyc(1);
    lit("shows_A", 4'b1110, 7'b0001000);
    wait_fs();
    cyc(2);
    lit("shows_5", 4'b1110, 7'b0010010);

    // Reset during digit2 SHOW with pending full
    send(16'h9999);
    check("pend_full_ready", 16'(din_ready), 16'd0);
    cyc(11);
    lit("d2_before_rst", 4'b1011, 7'b0010010);
    rst = 1'b1;
    cyc(1);
    lit("mid_rst", 4'b1111, 7'b1111111);
    check("mid_rst_ready", 16'(din_ready), 16'd1);
    check("mid_rst_fs", 16'(frame_start), 16'd0);
    rst = 1'b0;
    cyc(2);
    lit("after_rst_d0", 4'b1110, 7'b1000000);
    wait_fs();
    cyc(2);
    lit("pend_dropped", 4'b1110, 7'b1000000);

    // Leading zeros
    send(16'h0050);
    wait_fs();
    cyc(2);
    lit("lz_d0", 4'b1110, 7'b1000000);
    cyc(6);
    lit("lz_d1", 4'b1101, 7'b0010010);
    cyc(6);
`ifdef SEG_SCAN_LZB_EN
    lit("lz_d2", 4'b1111, 7'b1111111);
    cyc(6);
    lit("lz_d3", 4'b1111, 7'b1111111);
`else
    lit("lz_d2", 4'b1011, 7'b1000000);
    cyc(6);
    lit("lz_d3", 4'b0111, 7'b1000000);
`endif

    // Random traffic and occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      din_valid = ($urandom_range(0, 3) == 0);
      din       = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      cyc(1);
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    cyc(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
